// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-organised data RAM responder with programmable response latency
// One outstanding request; a dead RESP cycle separates completions so a held request re-issues cleanly.
module dmem_responder #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h1c000000,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  wmask,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        write_finish,
  output logic        range_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        accept, complete;

  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wmask_q;

  logic        sel_we;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_wmask;
  logic [31:0] off;
  logic        in_range;
  logic [ADDR_WIDTH-1:0] idx;

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  // cnt holds the number of further WAIT cycles before the response edge
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_nx = RESP;
            complete = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = 4'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (!en) begin
          state_nx = IDLE;
        end else if (cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
        end else begin
          state_nx = RESP;
          complete = 1'b1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With LATENCY=1 the completing edge is the accept edge, so use the live inputs there
  always_comb begin
    sel_we    = (state == IDLE) ? we    : we_q;
    sel_addr  = (state == IDLE) ? addr  : addr_q;
    sel_wmask = (state == IDLE) ? wmask : wmask_q;
    sel_wdata = (state == IDLE) ? wdata : wdata_q;
    off       = sel_addr - BASE_ADDR;
    in_range  = off < (32'd4 << ADDR_WIDTH);
    idx       = off[ADDR_WIDTH+1:2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      rdata        <= 32'd0;
      rdata_valid  <= 1'b0;
      write_finish <= 1'b0;
      range_err    <= 1'b0;
      busy         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wmask_q      <= 4'd0;
      wdata_q      <= 32'd0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      rdata_valid  <= complete & ~sel_we;
      write_finish <= complete & sel_we;
      range_err    <= complete & ~in_range;
      busy         <= (state_nx != IDLE);
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wmask_q <= wmask;
        wdata_q <= wdata;
      end
      if (complete && !sel_we) begin
        rdata <= in_range ? mem[idx] : 32'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && complete && sel_we && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_wmask[i]) begin
          mem[idx][8*i +: 8] <= sel_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
